// File: rtl/alu_mult_sequencer.sv
// Sequential 4x4 unsigned shift-and-add multiplier built around one 4-bit ripple-carry adder,
// with a start/busy/done handshake and seven-segment views of the operands and product.

module RippleCarryAdder4 (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic c1, c2, c3;

  assign sum[0] = x[0] ^ y[0] ^ cin;
  assign c1     = (x[0] & y[0]) | (cin & (x[0] ^ y[0]));
  assign sum[1] = x[1] ^ y[1] ^ c1;
  assign c2     = (x[1] & y[1]) | (c1 & (x[1] ^ y[1]));
  assign sum[2] = x[2] ^ y[2] ^ c2;
  assign c3     = (x[2] & y[2]) | (c2 & (x[2] ^ y[2]));
  assign sum[3] = x[3] ^ y[3] ^ c3;
  assign cout   = (x[3] & y[3]) | (c3 & (x[3] ^ y[3]));

endmodule

module alu_mult_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] product,
  output logic       busy,
  output logic       done,
  output logic [6:0] hex0,
  output logic [6:0] hex1,
  output logic [6:0] hex2,
  output logic [6:0] hex3
);

  typedef enum logic [1:0] {IDLE, ADD, SHIFT, DONE} state_t;

  state_t     state;
  logic [3:0] m;
  logic [3:0] q;
  logic [4:0] acc;
  logic [1:0] cnt;
  logic [3:0] a_cap;
  logic [3:0] b_cap;
  logic [3:0] sum;
  logic       cout;

  RippleCarryAdder4 u_adder (
    .x    (acc[3:0]),
    .y    (m),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  // Product is loaded on the final SHIFT edge with the post-shift value so it is
  // already valid during DONE; acc[4] keeps the carry so 15x15 does not overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      m       <= '0;
      q       <= '0;
      acc     <= '0;
      cnt     <= '0;
      a_cap   <= '0;
      b_cap   <= '0;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            m     <= a;
            q     <= b;
            a_cap <= a;
            b_cap <= b;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ADD;
          end
        end
        ADD: begin
          if (q[0]) acc <= {cout, sum};
          else      acc <= {1'b0, acc[3:0]};
          state <= SHIFT;
        end
        SHIFT: begin
          q   <= {acc[0], q[3:1]};
          acc <= {1'b0, acc[4:1]};
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) begin
            product <= {acc, q[3:1]};
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end else begin
            state <= ADD;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Active-low segments, bit 0 = segment a through bit 6 = segment g.
  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: seg7 = 7'b1000000;
      4'h1: seg7 = 7'b1111001;
      4'h2: seg7 = 7'b0100100;
      4'h3: seg7 = 7'b0110000;
      4'h4: seg7 = 7'b0011001;
      4'h5: seg7 = 7'b0010010;
      4'h6: seg7 = 7'b0000010;
      4'h7: seg7 = 7'b1111000;
      4'h8: seg7 = 7'b0000000;
      4'h9: seg7 = 7'b0010000;
      4'hA: seg7 = 7'b0001000;
      4'hB: seg7 = 7'b0000011;
      4'hC: seg7 = 7'b1000110;
      4'hD: seg7 = 7'b0100001;
      4'hE: seg7 = 7'b0000110;
      default: seg7 = 7'b0001110;
    endcase
  endfunction

  assign hex0 = seg7(product[3:0]);
  assign hex1 = seg7(product[7:4]);
  assign hex2 = seg7(b_cap);
  assign hex3 = seg7(a_cap);

endmodule

// File: tb/tb_alu_mult_sequencer.sv
// Scoreboard bench for alu_mult_sequencer: stimulus pushes expected products,
// a negedge monitor pops and checks them whenever done pulses.

module tb_alu_mult_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic [7:0] product;
  logic       busy;
  logic       done;
  logic [6:0] hex0;
  logic [6:0] hex1;
  logic [6:0] hex2;
  logic [6:0] hex3;

  typedef struct {
    logic [7:0] prod;
    logic [3:0] opA;
    logic [3:0] opB;
    int         startCyc;
  } exp_t;

  exp_t sbQ[$];
  exp_t popped;
  int   compared = 0;
  int   mismatched = 0;
  int   cyc = 0;
  int   busyRun = 0;
  bit   expectIdle = 1'b0;
  bit   endReq = 1'b0;
  bit   endAck = 1'b0;

  // Hand-written active-low digit patterns 0..F, segment a in bit 0.
  logic [6:0] segTable [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  always #5 clk = ~clk;

  alu_mult_sequencer dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .a       (a),
    .b       (b),
    .product (product),
    .busy    (busy),
    .done    (done),
    .hex0    (hex0),
    .hex1    (hex1),
    .hex2    (hex2),
    .hex3    (hex3)
  );

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Monitor: every check happens here so that stimulus only schedules work.
  always @(negedge clk) begin
    if (reset) begin
      busyRun = 0;
    end else begin
      checkOutput("busy_done_exclusive", int'(busy & done), 0);
      if (expectIdle) begin
        checkOutput("idle_product", int'(product), 0);
        checkOutput("idle_busy", int'(busy), 0);
        checkOutput("idle_done", int'(done), 0);
        checkOutput("idle_hex0", int'(hex0), 7'b1000000);
        checkOutput("idle_hex1", int'(hex1), 7'b1000000);
        checkOutput("idle_hex2", int'(hex2), 7'b1000000);
        checkOutput("idle_hex3", int'(hex3), 7'b1000000);
      end
      if (busy) busyRun++;
      if (done) begin
        if (sbQ.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpected_done: got done=1 with product 'h%0h, expected no done (cycle %0d)", product, cyc);
        end else begin
          popped = sbQ.pop_front();
          checkOutput("product", int'(product), int'(popped.prod));
          checkOutput("hex0", int'(hex0), int'(segTable[popped.prod[3:0]]));
          checkOutput("hex1", int'(hex1), int'(segTable[popped.prod[7:4]]));
          checkOutput("hex2", int'(hex2), int'(segTable[popped.opB]));
          checkOutput("hex3", int'(hex3), int'(segTable[popped.opA]));
          checkOutput("latency", cyc - popped.startCyc, 9);
          checkOutput("busy_cycles", busyRun, 8);
        end
        busyRun = 0;
      end
      if (endReq && !endAck) begin
        checkOutput("pending_ops", sbQ.size(), 0);
        endAck = 1'b1;
      end
    end
  end

  // One start pulse; operands are scrambled after acceptance, and with poke set
  // start is also raised during ADD/SHIFT and DONE where it must be ignored.
  task automatic applyStimulus(input logic [3:0] ta, input logic [3:0] tbv,
                               input logic [7:0] expProd, input bit poke);
    a = ta;
    b = tbv;
    start = 1'b1;
    @(negedge clk);
    sbQ.push_back('{expProd, ta, tbv, cyc});
    @(posedge clk);
    #1;
    a = ~ta;
    b = ~tbv;
    for (int k = 1; k <= 9; k++) begin
      start = poke && (k == 5 || k == 9);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
  endtask

  initial begin
    int c0;
    reset = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    expectIdle = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    expectIdle = 1'b0;

    applyStimulus(4'd3,  4'd5,  8'h0F, 1'b1);
    applyStimulus(4'd15, 4'd15, 8'hE1, 1'b0);
    applyStimulus(4'd0,  4'd9,  8'h00, 1'b0);
    applyStimulus(4'd9,  4'd0,  8'h00, 1'b1);

    // start held high: back-to-back operations, a changes mid-flight
    a = 4'd2;
    b = 4'd7;
    start = 1'b1;
    @(negedge clk);
    c0 = cyc;
    sbQ.push_back('{8'h0E, 4'd2, 4'd7, c0});
    sbQ.push_back('{8'h1C, 4'd4, 4'd7, c0 + 10});
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    a = 4'd4;
    repeat (8) begin
      @(posedge clk);
      #1;
    end
    for (int k = 11; k <= 19; k++) begin
      start = (k == 13 || k == 16);
      @(posedge clk);
      #1;
    end
    start = 1'b0;

    // abort mid-operation with reset; no done may follow
    a = 4'd6;
    b = 4'd6;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    expectIdle = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    expectIdle = 1'b0;

    applyStimulus(4'd12, 4'd11, 8'h84, 1'b0);

    endReq = 1'b1;
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/alu_mult_sequencer.md
# alu_mult_sequencer

Multi-cycle 4x4 unsigned shift-and-add multiplier controller that sequences the team's 4-bit ripple-carry adder datapath. An FSM drives one adder instance (cin tied 0) over four add/shift iterations and returns an 8-bit product with a start/busy/done handshake. It sits beside the combinational ALU on the board: operands come from switches and the result goes to LEDs and seven-segment displays.

## Interface

Parameters:
- none; operand width is fixed at 4 and product width at 8.

Ports:
- clk  in  1  single system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk.
- start  in  1  request; sampled only in IDLE.
- a  in  4  multiplicand; captured when start is accepted.
- b  in  4  multiplier; captured when start is accepted.
- product  out  8  registered result; holds until the next completion or reset.
- busy  out  1  high while in ADD or SHIFT.
- done  out  1  one-cycle pulse in DONE.
- hex0  out  7  seven-segment display of product[3:0].
- hex1  out  7  seven-segment display of product[7:4].
- hex2  out  7  seven-segment display of the captured b.
- hex3  out  7  seven-segment display of the captured a.

## Operation

- Registers:
  - m[3:0]: multiplicand.
  - q[3:0]: multiplier/low product.
  - acc[4:0]: high partial, bit 4 = adder carry.
  - cnt[1:0]: iteration count.
  - a_cap, b_cap: captured operands for display.
  - product[7:0].
- FSM states: IDLE, ADD, SHIFT, DONE.
- IDLE:
  - If start=1: m<=a, q<=b, a_cap<=a, b_cap<=b, acc<=0, cnt<=0, go to ADD.
  - Otherwise stay in IDLE.
- ADD:
  - If q[0]=1: acc<={cout, sum}, where the adder inputs are acc[3:0] and m.
  - Else acc<={1'b0, acc[3:0]}.
  - Always go to SHIFT.
- SHIFT:
  - Logical right shift of {acc, q} by 1: q<={acc[0], q[3:1]}, acc<={1'b0, acc[4:1]}.
  - cnt<=cnt+1.
  - If cnt==3 (before increment), go to DONE; else go to ADD.
- DONE:
  - product<={acc[3:0], q}, visible in this state; done=1.
  - Unconditionally go to IDLE.
- Arithmetic is unsigned modulo 2^8. 15x15 must produce 225 with no overflow, since the carry is retained in acc[4].
- start in ADD, SHIFT or DONE is ignored. It causes no queueing and no operand recapture.
- start held high continuously starts a new operation on every IDLE visit.
- a/b changing during an operation has no effect on the result.
- Displays:
  - Segments are active-low, bit 0 = segment a … bit 6 = segment g, hex 0–F, same encoding as the team's seven-segment decoder.
  - Combinational from registered values.
- Reset, including mid-operation:
  - State goes to IDLE; all registers, including product, cleared to 0; busy=0, done=0.
  - hex0–hex3 = 7'b1000000 (digit 0).
  - An aborted operation never pulses done.

## Timing

- Cycle 0: start=1 sampled in IDLE.
- Cycles 1–8: ADD/SHIFT alternating (ADD on odd cycles); busy=1.
- Cycle 9: DONE; done=1, busy=0, product valid from this cycle.
- Cycle 10: IDLE; start can be accepted here.
- Latency from start to done is 9 cycles; minimum initiation interval is 10 cycles.
- busy and done are never high together.
- product changes only on entry to DONE or on reset.

## Test plan

- Reset held for 2 cycles, then released with start=0:
  - product=8'h00, busy=0, done=0.
  - hex0–hex3=7'b1000000, stable for 20 cycles.
- a=3, b=5, start pulsed 1 cycle:
  - busy high cycles 1–8, done high only in cycle 9.
  - product=8'h0F, hex0=7'b0001110, hex1=7'b1000000.
- a=15, b=15:
  - product=8'hE1 (225), which exercises the carry into acc[4].
  - hex1=7'b0000110, hex0=7'b1111001.
- a=0, b=9 → product=8'h00. a=9, b=0 → product=8'h00. Both complete in 9 cycles.
- start held high with a=2, b=7, then a changed to 4 at cycle 3:
  - First done at cycle 9 with product=8'h0E.
  - Second operation accepted at cycle 10 using a=4; done at cycle 19 with product=8'h1C.
  - Pulses of start during busy cause no extra done pulses.
- a=6, b=6 started, reset=1 at cycle 4:
  - State IDLE and product=8'h00 at cycle 5; busy=0.
  - No done pulse in the following 15 cycles.
